detect_arbiter: RTL

DETECT_ARBITER -- requirements
Module: detect_arbiter

---
 rtl/detect_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/detect_arbiter.sv
// detect_arbiter: round-robin arbiter that grants one of four requesters a serial
// detection burst and reports the number of 0->1 hits. Optional macro: DET_ABORT_EN.
module detect_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       w_in,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_id,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             aborted,
  output logic [1:0]       state_dbg
);
  // Handshake: req[i] is a level request sampled in IDLE; while gnt[i]=1 requester i
  // supplies one w_in[i] bit per cycle; done pulses for one cycle and done_id, hit_cnt,
  // aborted are valid from that cycle until the next done pulse.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [1:0]       DET_A    = 2'd0;
  localparam logic [1:0]       DET_B    = 2'd1;
  localparam logic [1:0]       DET_C    = 2'd2;
  localparam logic [7:0]       LAST_BIT = 8'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] HIT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [1:0]       det, det_nxt;
  logic [7:0]       bit_cnt;
  logic [1:0]       cur_id, last_id, win_id;
  logic [CNT_W-1:0] acc, acc_nxt;
  logic             w_bit, hit, last_sample, abort_now;

  // Search starts just after the previous winner; k=4 wraps back to last_id itself.
  always_comb begin
    win_id = last_id;
    for (int k = 4; k >= 1; k--) begin
      if (req[2'(last_id + 2'(k))]) win_id = 2'(last_id + 2'(k));
    end
  end

  assign w_bit       = w_in[cur_id];
  assign last_sample = (state == RUN) && (bit_cnt == LAST_BIT);
  assign hit         = (det == DET_A) && w_bit;
  assign acc_nxt     = (hit && (acc != HIT_MAX)) ? acc + CNT_W'(1) : acc;

`ifdef DET_ABORT_EN
  assign abort_now = (state == RUN) && !req[cur_id];
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    det_nxt = DET_A;
    case (det)
      DET_A:   det_nxt = w_bit ? DET_B : DET_A;
      DET_B:   det_nxt = w_bit ? DET_C : DET_A;
      DET_C:   det_nxt = w_bit ? DET_C : DET_A;
      default: det_nxt = DET_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = RUN;
      RUN:     if (abort_now || last_sample) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = 4'b0000;
    if (state == RUN) gnt[cur_id] = 1'b1;
    busy      = (state != IDLE);
    done      = (state == REPORT);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det     <= DET_A;
      bit_cnt <= '0;
      cur_id  <= 2'd0;
      last_id <= 2'd3;
      acc     <= '0;
      done_id <= 2'd0;
      hit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            cur_id  <= win_id;
            last_id <= win_id;
            det     <= DET_A;
            bit_cnt <= '0;
            acc     <= '0;
          end
        end
        RUN: begin
          if (!abort_now) begin
            det     <= det_nxt;
            bit_cnt <= bit_cnt + 8'd1;
            acc     <= acc_nxt;
          end
          // Result registers load on entry to REPORT so they are valid with done.
          if (abort_now || last_sample) begin
            done_id <= cur_id;
            hit_cnt <= abort_now ? acc : acc_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DET_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      aborted <= 1'b0;
    else if (abort_now || last_sample)            aborted <= abort_now;
  end
`else
  assign aborted = 1'b0;
`endif

endmodule
